// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the scoreboard writeback port among NR_PORTS units.
// Define WB_EX_PRIO_EN to let requesters carrying an exception win arbitration first.
module wb_port_arbiter #(
  parameter int unsigned NR_PORTS      = 4,
  parameter int unsigned TRANS_ID_BITS = 2,
  parameter int unsigned DATA_WIDTH    = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NR_PORTS-1:0]                wb_valid_i,
  output logic [NR_PORTS-1:0]                wb_ready_o,
  input  logic [NR_PORTS*TRANS_ID_BITS-1:0]  wb_trans_id_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]     wb_data_i,
  input  logic [NR_PORTS-1:0]                wb_ex_valid_i,
  output logic                               sb_valid_o,
  input  logic                               sb_ready_i,
  output logic [TRANS_ID_BITS-1:0]           sb_trans_id_o,
  output logic [DATA_WIDTH-1:0]              sb_data_o,
  output logic                               sb_ex_valid_o,
  output logic [$clog2(NR_PORTS)-1:0]        sb_port_o
);

  localparam int unsigned PORT_W = $clog2(NR_PORTS);

  logic [TRANS_ID_BITS-1:0] w_tid  [NR_PORTS];
  logic [DATA_WIDTH-1:0]    w_data [NR_PORTS];
  logic [NR_PORTS-1:0]      w_cand;
  logic                     w_load_en;
  logic                     w_grant;
  logic [PORT_W-1:0]        w_winner;
  logic [PORT_W-1:0]        w_rr_next;

  logic                     r_valid;
  logic [TRANS_ID_BITS-1:0] r_tid;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_ex;
  logic [PORT_W-1:0]        r_port;
  logic [PORT_W-1:0]        r_rr;

  genvar gi;
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_port
      assign w_tid[gi]      = wb_trans_id_i[gi*TRANS_ID_BITS +: TRANS_ID_BITS];
      assign w_data[gi]     = wb_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wb_ready_o[gi] = w_load_en && w_grant && (w_winner == PORT_W'(gi));
    end
  endgenerate

  // rst_ni gates the handshake so nothing is acknowledged while reset is held.
  assign w_load_en = rst_ni && (!r_valid || sb_ready_i) && !flush_i;

`ifdef WB_EX_PRIO_EN
  logic [NR_PORTS-1:0] w_ex_req;
  assign w_ex_req = wb_valid_i & wb_ex_valid_i;
  assign w_cand   = (|w_ex_req) ? w_ex_req : wb_valid_i;
`else
  assign w_cand   = wb_valid_i;
`endif

  // Walk offsets from farthest to nearest so the port closest to r_rr overrides.
  always_comb begin
    int idx;
    idx      = 0;
    w_grant  = 1'b0;
    w_winner = '0;
    for (int off = int'(NR_PORTS) - 1; off >= 0; off--) begin
      idx = int'(r_rr) + off;
      if (idx >= int'(NR_PORTS)) begin
        idx = idx - int'(NR_PORTS);
      end
      if (w_cand[PORT_W'(idx)]) begin
        w_grant  = 1'b1;
        w_winner = PORT_W'(idx);
      end
    end
  end

  assign w_rr_next = (int'(w_winner) == int'(NR_PORTS) - 1) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_tid   <= '0;
      r_data  <= '0;
      r_ex    <= 1'b0;
      r_port  <= '0;
      r_rr    <= '0;
    end else if (w_load_en) begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_tid  <= w_tid[w_winner];
        r_data <= w_data[w_winner];
        r_ex   <= wb_ex_valid_i[w_winner];
        r_port <= w_winner;
        r_rr   <= w_rr_next;
      end
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end
  end

  assign sb_valid_o    = r_valid;
  assign sb_trans_id_o = r_tid;
  assign sb_data_o     = r_data;
  assign sb_ex_valid_o = r_ex;
  assign sb_port_o     = r_port;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter; the reference model follows
// WB_EX_PRIO_EN the same way the design does.
module tb_wb_port_arbiter;

  localparam int NP = 4;
  localparam int TB = 2;
  localparam int DW = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic [NP-1:0]     wb_valid_i = '0;
  logic [NP-1:0]     wb_ready_o;
  logic [NP*TB-1:0]  wb_trans_id_i = '0;
  logic [NP*DW-1:0]  wb_data_i = '0;
  logic [NP-1:0]     wb_ex_valid_i = '0;
  logic              sb_valid_o;
  logic              sb_ready_i = 1'b0;
  logic [TB-1:0]     sb_trans_id_o;
  logic [DW-1:0]     sb_data_o;
  logic              sb_ex_valid_o;
  logic [1:0]        sb_port_o;

  wb_port_arbiter #(.NR_PORTS(NP), .TRANS_ID_BITS(TB), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .wb_valid_i    (wb_valid_i),
    .wb_ready_o    (wb_ready_o),
    .wb_trans_id_i (wb_trans_id_i),
    .wb_data_i     (wb_data_i),
    .wb_ex_valid_i (wb_ex_valid_i),
    .sb_valid_o    (sb_valid_o),
    .sb_ready_i    (sb_ready_i),
    .sb_trans_id_o (sb_trans_id_o),
    .sb_data_o     (sb_data_o),
    .sb_ex_valid_o (sb_ex_valid_o),
    .sb_port_o     (sb_port_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]    port;
    logic [TB-1:0] tid;
    logic [DW-1:0] data;
    logic          ex;
  } wb_item_t;

  wb_item_t      exp_q[$];
  bit            have [NP];
  wb_item_t      held [NP];
  int            m_rr = 0;
  bit            m_valid = 1'b0;
  bit            exp_out_valid = 1'b0;
  logic [NP-1:0] exp_ready = '0;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Requesters present a new item only once the previous one was accepted.
  task automatic drive(input int preq, input int prdy, input int pfl);
    for (int p = 0; p < NP; p++) begin
      if (!have[p] && $urandom_range(99) < preq) begin
        have[p]      = 1'b1;
        held[p].port = 2'(p);
        held[p].tid  = TB'($urandom);
        held[p].data = {$urandom, $urandom};
        held[p].ex   = ($urandom_range(3) == 0);
      end
      wb_valid_i[p]            = have[p];
      wb_trans_id_i[p*TB +: TB] = held[p].tid;
      wb_data_i[p*DW +: DW]     = held[p].data;
      wb_ex_valid_i[p]         = held[p].ex;
    end
    sb_ready_i = ($urandom_range(99) < prdy);
    flush_i    = ($urandom_range(99) < pfl);
  endtask

  // Winner is the eligible port at the smallest forward distance from the pointer.
  task automatic model();
    bit any_ex;
    bit load_en;
    int best;
    int bestd;
    int d;
    bit elig;
    exp_out_valid = m_valid;
    load_en = (!m_valid || sb_ready_i) && !flush_i;
    any_ex = 1'b0;
    for (int p = 0; p < NP; p++) if (have[p] && held[p].ex) any_ex = 1'b1;
    best = -1;
    bestd = NP;
    for (int p = 0; p < NP; p++) begin
`ifdef WB_EX_PRIO_EN
      elig = have[p] && (!any_ex || held[p].ex);
`else
      elig = have[p];
`endif
      d = (p - m_rr + NP) % NP;
      if (elig && d < bestd) begin
        best = p;
        bestd = d;
      end
    end
    exp_ready = '0;
    if (load_en) begin
      if (best >= 0) begin
        exp_ready = 4'(1 << best);
        exp_q.push_back(held[best]);
        have[best] = 1'b0;
        m_rr = (best + 1) % NP;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (flush_i) begin
      m_valid = 1'b0;
    end
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic run(input int n, input int preq, input int prdy, input int pfl);
    for (int c = 0; c < n; c++) begin
      drive(preq, prdy, pfl);
      #1;
      model();
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_sb_valid", 128'(sb_valid_o), 128'(0));
    mon_en = 1'b0;
    exp_q.delete();
    m_valid = 1'b0;
    m_rr = 0;
    exp_out_valid = 1'b0;
    exp_ready = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("reset_sb_valid", 128'(sb_valid_o), 128'(0));
      check("reset_wb_ready", 128'(wb_ready_o), 128'(0));
    end else if (mon_en) begin
      check("wb_ready", 128'(wb_ready_o), 128'(exp_ready));
      check("sb_valid", 128'(sb_valid_o), 128'(exp_out_valid));
      if (exp_out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_payload: got output with empty expectation queue at %0t", $time);
        end else begin
          check("sb_payload", 128'({sb_port_o, sb_trans_id_o, sb_data_o, sb_ex_valid_o}),
                128'(exp_q[0]));
          if (sb_ready_i || flush_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < NP; p++) have[p] = 1'b0;
    rst_ni = 1'b0;
    drive(100, 0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
    run(20, 100, 100, 0);
    run(200, 60, 50, 5);
    run(60, 100, 20, 0);
    run(60, 15, 80, 10);
    run(10, 100, 0, 0);
    mid_reset();
    run(200, 50, 70, 5);
    run(100, 30, 90, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
